// File: rtl/ip_hs_tx_queue.sv
// Sending side of a 4-phase req/ack clock-domain crossing: a small FIFO feeds
// a level-held req/reqData pair that completes against a synchronized ack.
module ip_hs_tx_queue #(
  parameter int DATAWIDTH  = 32,
  parameter int DEPTH      = 4,
  parameter int SYNCSTAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  input  logic [DATAWIDTH-1:0]       inData,
  output logic                       inReady,
  output logic                       req,
  output logic [DATAWIDTH-1:0]       reqData,
  input  logic                       ack,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATAWIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;
  logic                   r_req;
  logic [DATAWIDTH-1:0]   r_req_data;
  logic [SYNCSTAGES-1:0]  r_ack_sync;
  logic [SYNCSTAGES-1:0]  r_sync_fill;
  logic                   r_armed;

  logic w_push;
  logic w_pop;
  logic w_ack_sync;
  logic w_sync_valid;
  logic w_armed;
  logic w_not_empty;

  assign inReady      = (r_level != FULL_LEVEL) && !reset;
  assign w_push       = inValid && inReady;
  assign w_not_empty  = (r_level != '0);
  assign w_ack_sync   = r_ack_sync[SYNCSTAGES-1];
  // The synchronizer only reflects the real ack once its reset zeros have
  // flushed; until then a low ackSync must not count as "ack seen low".
  assign w_sync_valid = r_sync_fill[SYNCSTAGES-1];
  assign w_armed      = r_armed || (w_sync_valid && !w_ack_sync);

  assign req     = r_req;
  assign reqData = r_req_data;
  assign level   = r_level;
  assign busy    = (r_state != S_IDLE) || w_not_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack_sync  <= '0;
      r_sync_fill <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_ack_sync  <= {r_ack_sync[SYNCSTAGES-2:0], ack};
      r_sync_fill <= {r_sync_fill[SYNCSTAGES-2:0], 1'b1};
      if (w_sync_valid && !w_ack_sync) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_not_empty && !w_ack_sync && w_armed) w_state_next = S_REQ;
      S_REQ:     if (w_ack_sync) w_state_next = S_RELEASE;
      S_RELEASE: if (!w_ack_sync) w_state_next = w_not_empty ? S_REQ : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:    w_pop = w_not_empty && !w_ack_sync && w_armed;
      S_RELEASE: w_pop = w_not_empty && !w_ack_sync;
      default:   w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= inData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_req      <= 1'b0;
      r_req_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_req_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_req <= (w_state_next == S_REQ);
    end
  end

endmodule
